mem_ctrl: RTL and testbench

- Fill-side partner of the instruction cache, and the only owner of the CPU's byte-wide external RAM port.
- On an icache miss it fetches a 32-bit instruction as 4 byte reads and presents it as `inst_rdy`/`inst_in` for the cache to write.
- It also serves load/store-buffer byte, half and word accesses.
- Arbitrates between the two requesters and serialises every access onto the 8-bit memory bus.

---
 rtl/mem_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// ============================================================================
// mem_ctrl -- byte-wide external RAM controller
//
// Owns the CPU's 8-bit RAM port. It serves two requesters: instruction-cache
// miss fills (always a 4-byte word) and load/store-buffer accesses (byte,
// half or word). Every access is serialised one byte per cycle onto the bus.
//
// Optional build macro:
//   MEM_CTRL_IO_STALL_EN - stores into the IO region (addr[17:16] == IO_HI)
//                          wait while io_buffer_full is high.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable; low freezes all state, forces mem_wr=0
//   flush             aborts an in-flight instruction fetch
//   if_req, if_addr   icache miss request / word-aligned address
//   inst_rdy, inst_in one-cycle fill pulse / fetched word (little-endian)
//   ls_req, ls_wr     LSB request / 1 = store
//   ls_size           00 byte, 01 half, 1x word
//   ls_addr, ls_wdata LSB byte address / store data (low bytes used)
//   ls_done, ls_rdata one-cycle completion pulse / zero-extended load data
//   mem_din           RAM read data (one cycle after mem_a)
//   mem_dout, mem_a   RAM write data / byte address
//   mem_wr            RAM write strobe
//   io_buffer_full    IO write backpressure
// ============================================================================
module mem_ctrl #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [1:0] IO_HI      = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  inst_rdy,
    output logic [31:0]           inst_in,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [2:0]              cnt_r, cnt_s;        // index of the next byte to issue
    logic                    valid_r, valid_s;    // a read was issued last active cycle
    logic [1:0]              last_r, last_s;      // byte count minus one
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [31:0]             wdata_r, wdata_s;
    logic [31:0]             data_r, data_s;      // read assembly buffer
    logic [31:0]             buf_s;
    logic [31:0]             inst_in_s, ls_rdata_s;
    logic                    inst_rdy_s, ls_done_s;
    logic [1:0]              cap_idx_s;
    logic [1:0]              size_last_s;
    logic                    accept_s;
    logic                    stall_s;

    // Zero-extends a small byte offset to address width.
    function automatic logic [ADDR_WIDTH-1:0] offset(input logic [2:0] idx);
        return {{(ADDR_WIDTH-3){1'b0}}, idx};
    endfunction

`ifdef MEM_CTRL_IO_STALL_EN
    assign stall_s = (state_r == LS_WR) && (addr_r[17:16] == IO_HI) && io_buffer_full;
`else
    // Stall disabled: tied to zero while keeping the IO inputs referenced.
    assign stall_s = 1'b0 & io_buffer_full & (addr_r[17:16] == IO_HI);
`endif

    // No accept during a done pulse so the requester can drop its request.
    assign accept_s = rdy && !inst_rdy && !ls_done;

    // Decode of the LSB size field into byte count minus one.
    always_comb begin
        case (ls_size)
            2'b00:   size_last_s = 2'd0;
            2'b01:   size_last_s = 2'd1;
            default: size_last_s = 2'd3;
        endcase
    end

    // Merge the byte arriving on mem_din into the assembly buffer.
    always_comb begin
        cap_idx_s = cnt_r[1:0] - 2'd1;
        buf_s     = data_r;
        buf_s[{cap_idx_s, 3'b000} +: 8] = mem_din;
    end

    // Next-state, datapath updates and RAM port drive.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        valid_s    = valid_r;
        last_s     = last_r;
        addr_s     = addr_r;
        wdata_s    = wdata_r;
        data_s     = data_r;
        inst_in_s  = inst_in;
        ls_rdata_s = ls_rdata;
        inst_rdy_s = 1'b0;
        ls_done_s  = 1'b0;
        mem_a      = '0;
        mem_dout   = 8'h00;
        mem_wr     = 1'b0;

        case (state_r)
            IDLE: begin
                if (accept_s && ls_req) begin
                    state_s = ls_wr ? LS_WR : LS_RD;
                    addr_s  = ls_addr;
                    wdata_s = ls_wdata;
                    last_s  = size_last_s;
                    cnt_s   = 3'd0;
                    valid_s = 1'b0;
                    data_s  = 32'h0000_0000;
                end else if (accept_s && if_req && !flush) begin
                    state_s = IF_RD;
                    addr_s  = if_addr;
                    last_s  = 2'd3;
                    cnt_s   = 3'd0;
                    valid_s = 1'b0;
                    data_s  = 32'h0000_0000;
                end else begin
                    state_s = IDLE;
                end
            end

            IF_RD, LS_RD: begin
                if (!rdy) begin
                    // Re-drive the byte whose capture is pending so its data
                    // is on mem_din again when rdy returns.
                    mem_a = addr_r + offset(valid_r ? {1'b0, cap_idx_s} : cnt_r);
                end else if (flush && (state_r == IF_RD)) begin
                    state_s = IDLE;
                    cnt_s   = 3'd0;
                    valid_s = 1'b0;
                end else begin
                    if (valid_r) begin
                        data_s = buf_s;
                    end else begin
                        data_s = data_r;
                    end
                    if (cnt_r <= {1'b0, last_r}) begin
                        mem_a   = addr_r + offset(cnt_r);
                        cnt_s   = cnt_r + 3'd1;
                        valid_s = 1'b1;
                    end else begin
                        // Final capture: finish and pulse done next cycle.
                        state_s = IDLE;
                        cnt_s   = 3'd0;
                        valid_s = 1'b0;
                        if (state_r == IF_RD) begin
                            inst_rdy_s = 1'b1;
                            inst_in_s  = buf_s;
                        end else begin
                            ls_done_s  = 1'b1;
                            ls_rdata_s = buf_s;
                        end
                    end
                end
            end

            LS_WR: begin
                mem_a    = addr_r + offset(cnt_r);
                mem_dout = wdata_r[{cnt_r[1:0], 3'b000} +: 8];
                if (rdy && !stall_s) begin
                    mem_wr = 1'b1;
                    if (cnt_r[1:0] == last_r) begin
                        state_s   = IDLE;
                        cnt_s     = 3'd0;
                        ls_done_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    mem_wr = 1'b0;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
                valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; hold behaviour under rdy=0 is in the next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 3'd0;
            valid_r  <= 1'b0;
            last_r   <= 2'd0;
            addr_r   <= '0;
            wdata_r  <= 32'h0000_0000;
            data_r   <= 32'h0000_0000;
            inst_rdy <= 1'b0;
            inst_in  <= 32'h0000_0000;
            ls_done  <= 1'b0;
            ls_rdata <= 32'h0000_0000;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            valid_r  <= valid_s;
            last_r   <= last_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            data_r   <= data_s;
            inst_rdy <= inst_rdy_s;
            inst_in  <= inst_in_s;
            ls_done  <= ls_done_s;
            ls_rdata <= ls_rdata_s;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// tb_mem_ctrl -- directed self-checking bench for mem_ctrl
// A small RAM model (4 KiB, address bits [11:0]) sits on the byte bus with
// one-cycle read latency; a preload port fills it before the tests.
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, if_req, ls_req, ls_wr, io_buffer_full;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_size;
    logic [7:0]  mem_din;
    logic        inst_rdy, ls_done, mem_wr;
    logic [31:0] inst_in, ls_rdata, mem_a;
    logic [7:0]  mem_dout;

    logic [7:0]  ram [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    int n_checks = 0;
    int n_pass   = 0;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_HI(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr),
        .inst_rdy(inst_rdy), .inst_in(inst_in),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, write on strobe, preload has priority.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_load(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick(); #1;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h expected 0", mem_a); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); else n_pass++;
        n_checks++; if (mem_dout !== 8'h0) $display("FAIL reset_mem_dout: got %h expected 0", mem_dout); else n_pass++;
        n_checks++; if (inst_rdy !== 1'b0) $display("FAIL reset_inst_rdy: got %b expected 0", inst_rdy); else n_pass++;
        n_checks++; if (ls_done !== 1'b0) $display("FAIL reset_ls_done: got %b expected 0", ls_done); else n_pass++;
        n_checks++; if (inst_in !== 32'h0) $display("FAIL reset_inst_in: got %h expected 0", inst_in); else n_pass++;
        n_checks++; if (ls_rdata !== 32'h0) $display("FAIL reset_ls_rdata: got %h expected 0", ls_rdata); else n_pass++;
    endtask

    task automatic test_word_fetch();
        if_req = 1'b1; if_addr = 32'h100; #1; tick();
        if_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (mem_a !== 32'h100 + i) $display("FAIL fetch_mem_a[%0d]: got %h expected %h", i, mem_a, 32'h100 + i); else n_pass++;
            n_checks++; if (mem_wr !== 1'b0) $display("FAIL fetch_mem_wr[%0d]: got %b expected 0", i, mem_wr); else n_pass++;
            tick();
        end
        #1;
        n_checks++; if (inst_rdy !== 1'b0) $display("FAIL fetch_early_rdy: got %b expected 0", inst_rdy); else n_pass++;
        tick(); #1;
        n_checks++; if (inst_rdy !== 1'b1) $display("FAIL fetch_inst_rdy: got %b expected 1", inst_rdy); else n_pass++;
        n_checks++; if (inst_in !== 32'h00100513) $display("FAIL fetch_inst_in: got %h expected 00100513", inst_in); else n_pass++;
        tick(); #1;
        n_checks++; if (inst_rdy !== 1'b0) $display("FAIL fetch_pulse_width: got %b expected 0", inst_rdy); else n_pass++;
    endtask

    task automatic test_simultaneous();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b00; ls_addr = 32'h204;
        if_req = 1'b1; if_addr = 32'h100; #1; tick();
        ls_req = 1'b0; #1;
        n_checks++; if (mem_a !== 32'h204) $display("FAIL sim_ls_first: got %h expected 00000204", mem_a); else n_pass++;
        tick(); tick(); #1;
        n_checks++; if (ls_done !== 1'b1) $display("FAIL sim_ls_done: got %b expected 1", ls_done); else n_pass++;
        n_checks++; if (ls_rdata !== 32'h000000FF) $display("FAIL sim_ls_rdata: got %h expected 000000ff", ls_rdata); else n_pass++;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL sim_blackout_a: got %h expected 0", mem_a); else n_pass++;
        tick(); #1;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL sim_idle_a: got %h expected 0", mem_a); else n_pass++;
        tick(); if_req = 1'b0; #1;
        n_checks++; if (mem_a !== 32'h100) $display("FAIL sim_if_accept: got %h expected 00000100", mem_a); else n_pass++;
        repeat (5) tick();
        #1;
        n_checks++; if (inst_rdy !== 1'b1) $display("FAIL sim_inst_rdy: got %b expected 1", inst_rdy); else n_pass++;
        n_checks++; if (inst_in !== 32'h00100513) $display("FAIL sim_inst_in: got %h expected 00100513", inst_in); else n_pass++;
        tick();
    endtask

    task automatic test_half_store();
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b01; ls_addr = 32'h300; ls_wdata = 32'hABCD1234;
        #1; tick();
        ls_req = 1'b0; #1;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h300, 8'h34}) $display("FAIL hst_byte0: got wr=%b a=%h d=%h expected wr=1 a=00000300 d=34", mem_wr, mem_a, mem_dout); else n_pass++;
        tick(); #1;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h301, 8'h12}) $display("FAIL hst_byte1: got wr=%b a=%h d=%h expected wr=1 a=00000301 d=12", mem_wr, mem_a, mem_dout); else n_pass++;
        tick(); #1;
        n_checks++; if (ls_done !== 1'b1) $display("FAIL hst_done: got %b expected 1", ls_done); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL hst_done_wr: got %b expected 0", mem_wr); else n_pass++;
        tick(); #1;
        n_checks++; if (ram[12'h302] !== 8'h5A) $display("FAIL hst_ram302: got %h expected 5a", ram[12'h302]); else n_pass++;
        n_checks++; if ({ram[12'h301], ram[12'h300]} !== 16'h1234) $display("FAIL hst_ram_written: got %h expected 1234", {ram[12'h301], ram[12'h300]}); else n_pass++;
        n_checks++; if (ls_rdata !== 32'h000000FF) $display("FAIL hst_rdata_hold: got %h expected 000000ff", ls_rdata); else n_pass++;
    endtask

    task automatic test_load_half();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b01; ls_addr = 32'h101; #1; tick();
        ls_req = 1'b0; #1;
        n_checks++; if (mem_a !== 32'h101) $display("FAIL lh_a0: got %h expected 00000101", mem_a); else n_pass++;
        tick(); #1;
        n_checks++; if (mem_a !== 32'h102) $display("FAIL lh_a1: got %h expected 00000102", mem_a); else n_pass++;
        tick(); #1;
        n_checks++; if (ls_done !== 1'b0) $display("FAIL lh_early_done: got %b expected 0", ls_done); else n_pass++;
        tick(); #1;
        n_checks++; if (ls_done !== 1'b1) $display("FAIL lh_done: got %b expected 1", ls_done); else n_pass++;
        n_checks++; if (ls_rdata !== 32'h00001005) $display("FAIL lh_rdata: got %h expected 00001005", ls_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h100; #1; tick();
        if_req = 1'b0; tick(); tick();
        flush = 1'b1; #1; tick();
        flush = 1'b0; if_req = 1'b1; if_addr = 32'h200; #1;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL flush_idle_a: got %h expected 0", mem_a); else n_pass++;
        n_checks++; if (inst_rdy !== 1'b0) $display("FAIL flush_no_rdy: got %b expected 0", inst_rdy); else n_pass++;
        tick(); if_req = 1'b0; #1;
        n_checks++; if (mem_a !== 32'h200) $display("FAIL flush_new_accept: got %h expected 00000200", mem_a); else n_pass++;
        for (int c = 5; c <= 10; c++) begin
            if (c > 5) #1;
            n_checks++; if (inst_rdy !== (c == 10)) $display("FAIL flush_rdy_c%0d: got %b expected %b", c, inst_rdy, (c == 10)); else n_pass++;
            tick();
        end
        n_checks++; if (inst_in !== 32'h44332211) $display("FAIL flush_inst_in: got %h expected 44332211", inst_in); else n_pass++;
    endtask

    task automatic test_rdy_stall();
        if_req = 1'b1; if_addr = 32'h100; #1; tick();
        if_req = 1'b0; tick();
        rdy = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            #1;
            n_checks++; if (mem_wr !== 1'b0) $display("FAIL rdy_wr_c%0d: got %b expected 0", c, mem_wr); else n_pass++;
            n_checks++; if (mem_a !== 32'h100) $display("FAIL rdy_redrive_c%0d: got %h expected 00000100", c, mem_a); else n_pass++;
            tick();
        end
        rdy = 1'b1;
        for (int c = 5; c <= 9; c++) begin
            #1;
            n_checks++; if (inst_rdy !== (c == 9)) $display("FAIL rdy_pulse_c%0d: got %b expected %b", c, inst_rdy, (c == 9)); else n_pass++;
            n_checks++; if (mem_wr !== 1'b0) $display("FAIL rdy_wr_c%0d: got %b expected 0", c, mem_wr); else n_pass++;
            if (c == 9) begin
                n_checks++; if (inst_in !== 32'h00100513) $display("FAIL rdy_inst_in: got %h expected 00100513", inst_in); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_store_io();
        int done_c;
        logic stall_en;
`ifdef MEM_CTRL_IO_STALL_EN
        stall_en = 1'b1;
`else
        stall_en = 1'b0;
`endif
        done_c = stall_en ? 7 : 5;
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'b10; ls_addr = 32'h30000; ls_wdata = 32'hDDCCBBAA;
        #1; tick();
        ls_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            io_buffer_full = (c == 2) || (c == 3);
            #1;
            n_checks++; if (ls_done !== (c == done_c)) $display("FAIL io_done_c%0d: got %b expected %b", c, ls_done, (c == done_c)); else n_pass++;
            if (c == 2) begin
                n_checks++; if (mem_wr !== !stall_en) $display("FAIL io_wr_c2: got %b expected %b", mem_wr, !stall_en); else n_pass++;
            end
            if (c == (stall_en ? 4 : 2)) begin
                n_checks++; if ({mem_a, mem_dout} !== {32'h30001, 8'hBB}) $display("FAIL io_byte1: got a=%h d=%h expected a=00030001 d=bb", mem_a, mem_dout); else n_pass++;
            end
            tick();
        end
        io_buffer_full = 1'b0;
    endtask

    task automatic test_wrap_load();
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'b10; ls_addr = 32'hFFFFFFFE; #1; tick();
        ls_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (mem_a !== 32'hFFFFFFFE + i) $display("FAIL wrap_a[%0d]: got %h expected %h", i, mem_a, 32'hFFFFFFFE + i); else n_pass++;
            tick();
        end
        tick(); #1;
        n_checks++; if (ls_done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", ls_done); else n_pass++;
        n_checks++; if (ls_rdata !== 32'hBBAA6677) $display("FAIL wrap_rdata: got %h expected bbaa6677", ls_rdata); else n_pass++;
        tick();
    endtask

    task automatic test_reset_abort();
        if_req = 1'b1; if_addr = 32'h200; #1; tick();
        if_req = 1'b0; tick();
        rst = 1'b1; #1; tick();
        rst = 1'b0;
        for (int c = 3; c <= 9; c++) begin
            #1;
            n_checks++; if (inst_rdy !== 1'b0) $display("FAIL rst_abort_c%0d: got %b expected 0", c, inst_rdy); else n_pass++;
            if (c == 3) begin
                n_checks++; if (mem_a !== 32'h0) $display("FAIL rst_abort_a: got %h expected 0", mem_a); else n_pass++;
            end
            tick();
        end
        n_checks++; if (inst_in !== 32'h0) $display("FAIL rst_abort_inst_in: got %h expected 0", inst_in); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        io_buffer_full = 1'b0; if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_size = 2'b00;
        pre_we = 1'b0; pre_addr = 12'h0; pre_data = 8'h0;
        ram_load(12'h100, 8'h13); ram_load(12'h101, 8'h05);
        ram_load(12'h102, 8'h10); ram_load(12'h103, 8'h00);
        ram_load(12'h200, 8'h11); ram_load(12'h201, 8'h22);
        ram_load(12'h202, 8'h33); ram_load(12'h203, 8'h44);
        ram_load(12'h204, 8'hFF);
        ram_load(12'h300, 8'h00); ram_load(12'h301, 8'h00); ram_load(12'h302, 8'h5A);
        ram_load(12'hFFE, 8'h77); ram_load(12'hFFF, 8'h66);
        test_reset();
        rst = 1'b0;
        tick();
        test_word_fetch();
        test_simultaneous();
        test_half_store();
        test_load_half();
        test_flush();
        test_rdy_stall();
        test_store_io();
        test_wrap_load();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
